// File: rtl/work_loader_ctrl_pkg.sv
// work_loader_pkg: shared types and constants for the work loader controller.
//   wl_state_e    - controller state encoding (IDLE=0, LOAD=1, READY=2, UNLOAD=3)
//   BYTE_W        - width of every byte lane (rx, tx, shift register top)
//   DEF_NUM_BYTES - default bytes per work unit (80-byte header)
//   DEF_OUT_BYTES - default result bytes shifted out per unload
package work_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_READY  = 2'd2,
    ST_UNLOAD = 2'd3
  } wl_state_e;

  localparam int BYTE_W        = 8;
  localparam int DEF_NUM_BYTES = 80;
  localparam int DEF_OUT_BYTES = 4;

endpackage

// File: rtl/work_loader_ctrl_if.sv
// work_loader_ctrl_if: bundles the UART rx/tx streams, the hasher handshake,
// the shift register control lines and the abort/status signals.
//   master : controller side (drives ready/valid/strobes/status)
//   slave  : environment side (UART, hasher, shift register, host)
// Optional: WORK_LOADER_TIMEOUT_EN adds the timeout_pulse status line.
interface work_loader_ctrl_if;
  import work_loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              work_valid;
  logic              work_ready;
  logic              unload_req;
  logic [BYTE_W-1:0] sr_top;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [BYTE_W-1:0] sr_d;
  logic              sr_enable;
  logic              sr_shift;
  logic              sr_reset;
  logic              clear;
  logic              busy;
`ifdef WORK_LOADER_TIMEOUT_EN
  logic              timeout_pulse;
`endif

  modport master (
    input  rx_data, rx_valid, work_ready, unload_req, sr_top, tx_ready, clear,
    output rx_ready, work_valid, tx_data, tx_valid, sr_d, sr_enable, sr_shift,
           sr_reset, busy
`ifdef WORK_LOADER_TIMEOUT_EN
    , output timeout_pulse
`endif
  );

  modport slave (
    output rx_data, rx_valid, work_ready, unload_req, sr_top, tx_ready, clear,
    input  rx_ready, work_valid, tx_data, tx_valid, sr_d, sr_enable, sr_shift,
           sr_reset, busy
`ifdef WORK_LOADER_TIMEOUT_EN
    , input timeout_pulse
`endif
  );

endinterface

// File: rtl/work_loader_ctrl_idle_timer.sv
// idle_timer: resettable saturating cycle counter with a terminal pulse.
// Only compiled when WORK_LOADER_TIMEOUT_EN is defined (the controller
// instantiates it only in that build).
//   clock  in  clock
//   reset  in  synchronous active-high reset
//   i_clr  in  synchronous restart to zero
//   i_en   in  count this cycle
//   o_term out high while enabled with the count at LIMIT-1
`ifdef WORK_LOADER_TIMEOUT_EN
module idle_timer #(
  parameter int LIMIT = 100000,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset || i_clr)             r_cnt <= '0;
    else if (i_en && r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
  end

  assign o_term = i_en && (r_cnt == LAST);

endmodule
`endif

// File: rtl/work_loader_ctrl.sv
// work_loader_ctrl: sequences the byte-wide work shift register.
//   Loads NUM_BYTES bytes from the UART rx stream, offers the work unit to
//   the hasher, and on unload_req streams OUT_BYTES bytes (MSB first, taken
//   from the register top) to the UART tx stream.
// Ports:
//   clock  in  single clock
//   reset  in  synchronous active-high reset
//   bus    work_loader_ctrl_if.master (rx/tx streams, hasher handshake,
//          shift register strobes, clear, busy[, timeout_pulse])
// Optional: WORK_LOADER_TIMEOUT_EN adds an inter-byte timeout in LOAD that
//   aborts like clear and raises timeout_pulse for one cycle.
module work_loader_ctrl
  import work_loader_pkg::*;
#(
  parameter int NUM_BYTES = DEF_NUM_BYTES,
  parameter int OUT_BYTES = DEF_OUT_BYTES,
  parameter int CNT_WIDTH = 7
`ifdef WORK_LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 100000
`endif
) (
  input  logic                clock,
  input  logic                reset,
  work_loader_ctrl_if.master  bus
);

  localparam logic [CNT_WIDTH-1:0] LOAD_LAST   = CNT_WIDTH'(NUM_BYTES - 1);
  localparam logic [CNT_WIDTH-1:0] UNLOAD_LAST = CNT_WIDTH'(OUT_BYTES - 1);

  wl_state_e            r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_byte_cnt, w_cnt_nxt;

  logic w_rx_ready, w_accept, w_tx_valid, w_shift, w_abort;

  // rx_ready looks only at the external clear, never at the timeout, so the
  // timer (which depends on Accept) cannot form a combinational loop. A
  // timeout can only fire on a cycle without Accept anyway.
  assign w_rx_ready = !reset && !bus.unload_req && !bus.clear &&
                      (r_state == ST_IDLE || r_state == ST_LOAD);
  assign w_accept   = bus.rx_valid && w_rx_ready;

`ifdef WORK_LOADER_TIMEOUT_EN
  logic w_timeout;

  idle_timer #(.LIMIT(TIMEOUT_CYCLES)) u_idle_timer (
    .clock  (clock),
    .reset  (reset),
    .i_clr  (r_state != ST_LOAD || w_accept || bus.clear),
    .i_en   (r_state == ST_LOAD && !w_accept),
    .o_term (w_timeout)
  );

  assign w_abort           = bus.clear || (w_timeout && !reset);
  assign bus.timeout_pulse = w_timeout && !reset && !bus.clear;
`else
  assign w_abort = bus.clear;
`endif

  assign w_tx_valid = !reset && !w_abort && (r_state == ST_UNLOAD);
  assign w_shift    = w_tx_valid && bus.tx_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_byte_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_byte_cnt;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // unload_req wins; rx_ready is already low while it is high
          if (bus.unload_req) begin
            w_state_nxt = ST_UNLOAD;
            w_cnt_nxt   = '0;
          end else if (w_accept) begin
            w_state_nxt = ST_LOAD;
            w_cnt_nxt   = CNT_WIDTH'(1);
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            w_cnt_nxt = r_byte_cnt + 1'b1;
            if (r_byte_cnt == LOAD_LAST) w_state_nxt = ST_READY;
          end
        end
        ST_READY: begin
          // register contents stay put for the hasher / a later unload
          if (bus.work_ready) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        ST_UNLOAD: begin
          if (w_shift) begin
            if (r_byte_cnt == UNLOAD_LAST) begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_byte_cnt + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign bus.rx_ready   = w_rx_ready;
  assign bus.sr_enable  = w_accept;
  assign bus.sr_d       = bus.rx_data;
  assign bus.tx_data    = bus.sr_top;
  assign bus.tx_valid   = w_tx_valid;
  assign bus.sr_shift   = w_shift;
  assign bus.sr_reset   = reset || w_abort;
  assign bus.work_valid = !reset && !w_abort && (r_state == ST_READY);
  assign bus.busy       = !reset && (r_state != ST_IDLE);

endmodule

// File: tb/tb_work_loader_ctrl.sv
module tb_work_loader_ctrl;
  import work_loader_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  work_loader_ctrl_if bus();

  work_loader_ctrl #(
    .NUM_BYTES(80), .OUT_BYTES(4), .CNT_WIDTH(7)
`ifdef WORK_LOADER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sr_mem [0:4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};

  // Drives n bytes (base, base+1, ...) with rx_valid held high; each driven
  // byte is pushed to the scoreboard and popped when sr_enable loads it.
  task automatic drive_bytes(input int n, input int base, output int n_en);
    logic [7:0] e;
    n_en = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'(base + i);
      exp_q.push_back(8'(base + i));
      #1;
      n_checks++;
      if (bus.rx_ready !== 1'b1) begin n_fail++; $display("FAIL load_rx_ready byte %0d: got %b want 1", i, bus.rx_ready); end
      n_checks++;
      if (bus.work_valid !== 1'b0) begin n_fail++; $display("FAIL load_work_valid_early byte %0d: got %b want 0", i, bus.work_valid); end
      n_checks++;
      if (bus.sr_enable !== 1'b1) begin
        n_fail++; $display("FAIL load_sr_enable byte %0d: got %b want 1", i, bus.sr_enable);
      end else begin
        n_en++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        n_checks++;
        if (bus.sr_d !== e) begin n_fail++; $display("FAIL load_sr_d byte %0d: got %h want %h", i, bus.sr_d, e); end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rx_valid = 1'b1; bus.rx_data = 8'hAA;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock); #1;
      n_checks++;
      if (bus.sr_reset !== 1'b1) begin n_fail++; $display("FAIL reset_sr_reset cyc %0d: got %b want 1", c, bus.sr_reset); end
      n_checks++;
      if (bus.rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready cyc %0d: got %b want 0", c, bus.rx_ready); end
      n_checks++;
      if ({bus.busy, bus.sr_enable, bus.tx_valid, bus.work_valid, bus.sr_shift} !== 5'b0) begin
        n_fail++; $display("FAIL reset_outputs cyc %0d: got %b want 00000", c,
          {bus.busy, bus.sr_enable, bus.tx_valid, bus.work_valid, bus.sr_shift});
      end
    end
    @(negedge clock);
    reset = 1'b0; bus.rx_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.rx_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_rx_ready: got %b want 1", bus.rx_ready); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", bus.busy); end
    n_checks++;
    if (bus.sr_reset !== 1'b0) begin n_fail++; $display("FAIL post_reset_sr_reset: got %b want 0", bus.sr_reset); end
  endtask

  task automatic test_load();
    int n_en;
    drive_bytes(80, 0, n_en);
    n_checks++;
    if (n_en != 80) begin n_fail++; $display("FAIL load_enable_count: got %0d want 80", n_en); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL load_scoreboard_left: got %0d want 0", exp_q.size()); end
    @(negedge clock);
    bus.rx_data = 8'h50;  // rx_valid stays high
    #1;
    n_checks++;
    if (bus.work_valid !== 1'b1) begin n_fail++; $display("FAIL load_work_valid: got %b want 1", bus.work_valid); end
    n_checks++;
    if (bus.rx_ready !== 1'b0 || bus.sr_enable !== 1'b0) begin
      n_fail++; $display("FAIL ready_rx_blocked: got rdy=%b en=%b want 0 0", bus.rx_ready, bus.sr_enable);
    end
  endtask

  task automatic test_ready_hold();
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      bus.work_ready = 1'b0; bus.rx_valid = 1'b1;
      #1;
      n_checks++;
      if (bus.work_valid !== 1'b1 || bus.rx_ready !== 1'b0 || bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL ready_hold cyc %0d: got wv=%b rdy=%b busy=%b want 1 0 1", c,
          bus.work_valid, bus.rx_ready, bus.busy);
      end
    end
    @(negedge clock);
    bus.work_ready = 1'b1; bus.rx_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.work_valid !== 1'b1) begin n_fail++; $display("FAIL ready_take_wv: got %b want 1", bus.work_valid); end
    @(negedge clock);
    bus.work_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.work_valid !== 1'b0 || bus.rx_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_to_idle: got busy=%b wv=%b rdy=%b want 0 0 1",
        bus.busy, bus.work_valid, bus.rx_ready);
    end
  endtask

  task automatic test_unload();
    int idx = 0;
    int shifts = 0;
    logic [7:0] e;
    exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    for (int c = 0; c < 40 && shifts < 4; c++) begin
      @(negedge clock);
      bus.unload_req = 1'b1;
      bus.tx_ready   = c[0];
      bus.sr_top     = sr_mem[idx];
      #1;
      n_checks++;
      if (bus.sr_shift !== (bus.tx_ready & (c > 0))) begin
        n_fail++; $display("FAIL unload_shift_coincident cyc %0d: got %b want %b", c, bus.sr_shift, bus.tx_ready & (c > 0));
      end
      if (c > 0) begin
        n_checks++;
        if (bus.tx_valid !== 1'b1) begin n_fail++; $display("FAIL unload_tx_valid cyc %0d: got %b want 1", c, bus.tx_valid); end
      end
      if (bus.sr_shift === 1'b1) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        n_checks++;
        if (bus.tx_data !== e) begin n_fail++; $display("FAIL unload_tx_data shift %0d: got %h want %h", shifts, bus.tx_data, e); end
        idx++; shifts++;
      end
    end
    n_checks++;
    if (shifts != 4) begin n_fail++; $display("FAIL unload_shift_count: got %0d want 4", shifts); end
    @(negedge clock);
    bus.unload_req = 1'b0; bus.tx_ready = 1'b1; bus.sr_top = sr_mem[idx];
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0 || bus.sr_shift !== 1'b0) begin
      n_fail++; $display("FAIL unload_back_idle: got busy=%b txv=%b sh=%b want 0 0 0",
        bus.busy, bus.tx_valid, bus.sr_shift);
    end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_priority();
    int n_sh = 0;
    @(negedge clock);
    bus.rx_valid = 1'b1; bus.rx_data = 8'h55; bus.unload_req = 1'b1;
    #1;
    n_checks++;
    if (bus.sr_enable !== 1'b0 || bus.rx_ready !== 1'b0) begin
      n_fail++; $display("FAIL prio_no_accept: got en=%b rdy=%b want 0 0", bus.sr_enable, bus.rx_ready);
    end
    @(negedge clock);
    bus.rx_valid = 1'b0; bus.unload_req = 1'b0; bus.tx_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.tx_valid !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL prio_in_unload: got txv=%b busy=%b want 1 1", bus.tx_valid, bus.busy);
    end
    for (int c = 0; c < 10 && bus.busy === 1'b1; c++) begin
      if (bus.sr_shift === 1'b1) n_sh++;
      @(negedge clock); #1;
    end
    n_checks++;
    if (n_sh != 4 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL prio_unload_finish: got shifts=%0d busy=%b want 4 0", n_sh, bus.busy);
    end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_clear();
    int n_en;
    drive_bytes(40, 8'h10, n_en);
    @(negedge clock);
    bus.rx_valid = 1'b1; bus.rx_data = 8'h38; bus.clear = 1'b1;
    #1;
    n_checks++;
    if (bus.sr_reset !== 1'b1 || bus.sr_enable !== 1'b0 || bus.rx_ready !== 1'b0) begin
      n_fail++; $display("FAIL clear_abort: got srr=%b en=%b rdy=%b want 1 0 0",
        bus.sr_reset, bus.sr_enable, bus.rx_ready);
    end
    @(negedge clock);
    bus.clear = 1'b0; bus.rx_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.sr_reset !== 1'b0 || bus.rx_ready !== 1'b1) begin
      n_fail++; $display("FAIL clear_to_idle: got busy=%b srr=%b rdy=%b want 0 0 1",
        bus.busy, bus.sr_reset, bus.rx_ready);
    end
  endtask

  // A full reload straight after the abort proves the byte counter restarted.
  task automatic test_back_to_back();
    int n_en;
    drive_bytes(80, 8'h80, n_en);
    n_checks++;
    if (n_en != 80) begin n_fail++; $display("FAIL b2b_enable_count: got %0d want 80", n_en); end
    @(negedge clock);
    bus.rx_valid = 1'b0; bus.work_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.work_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_work_valid: got %b want 1", bus.work_valid); end
    @(negedge clock);
    bus.work_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", bus.busy); end
  endtask

`ifdef WORK_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    int n_en;
    drive_bytes(5, 8'h20, n_en);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      bus.rx_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.timeout_pulse !== (k == 7) || bus.sr_reset !== (k == 7)) begin
        n_fail++; $display("FAIL timeout_pulse stall %0d: got tp=%b srr=%b want %b", k,
          bus.timeout_pulse, bus.sr_reset, (k == 7));
      end
    end
    @(negedge clock); #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.timeout_pulse !== 1'b0) begin
      n_fail++; $display("FAIL timeout_idle: got busy=%b tp=%b want 0 0", bus.busy, bus.timeout_pulse);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.rx_data = '0; bus.rx_valid = 1'b0; bus.work_ready = 1'b0;
    bus.unload_req = 1'b0; bus.sr_top = '0; bus.tx_ready = 1'b0; bus.clear = 1'b0;
    test_reset();
    test_load();
    test_ready_hold();
    test_unload();
    test_priority();
    test_clear();
    test_back_to_back();
`ifdef WORK_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
